pipe_run_ctrl: RTL
==================

// Module: pipe_run_ctrl
// PURPOSE
//  Run/halt/single-step controller for the 5-stage pipelined computer.
//  Generates one cycle-enable, pipe_en, that gates the PC register, all four
//  pipeline registers, the register-file write and the data-RAM write.
//  Commands come from a debug host over a valid/ready port; a PC-match
//  breakpoint halts the pipeline before the matching instruction is fetched.
// PARAMETERS
//  CNT_W  16  width of the STEP cycle count (taken from cmd_arg[CNT_W-1:0])
//  CYC_W  32  width of the enabled-cycle counter cycle_cnt
// PORTS
//  clock      in   1      system clock; all state updates on the rising edge
//  resetn     in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      command can be accepted this cycle
//  cmd_op     in   2      00 HALT, 01 RUN, 10 STEP, 11 SET_BP
//  cmd_arg    in   32     STEP: cycle count N; SET_BP: address, bit0=1 disables
//  pc         in   32     current PC, from the registered PC output of pipepc
//  pipe_en    out  1      pipeline cycle-enable
//  halted     out  1      1 when state==HALT
//  bp_hit     out  1      sticky: pipeline was stopped by the breakpoint
//  state      out  2      00 HALT, 01 RUN, 10 STEP
//  cycle_cnt  out  CYC_W  number of cycles with pipe_en=1
// BEHAVIOUR
//  Reset (async): state=HALT, step_left=0, bp_addr=0, bp_valid=0, bp_skip=0,
//   bp_hit=0, cycle_cnt=0. Outputs then: pipe_en=0, halted=1, cmd_ready=1.
//  Command accepted when cmd_valid & cmd_ready.
//   cmd_ready = (state != STEP). No commands are accepted during a STEP.
//  The state register updates at the clock edge that accepts the command.
//   pipe_en therefore follows the new state in the next cycle
//   (1-cycle latency).
//  HALT: next state HALT. RUN: next state RUN and bp_hit cleared.
//   RUN while already in RUN is a no-op apart from clearing bp_hit.
//  STEP: step_left <= (N==0) ? 1 : N; next state STEP; bp_hit cleared.
//  SET_BP: bp_addr <= {cmd_arg[31:2],2'b00}; bp_valid <= ~cmd_arg[0].
//   Accepted in HALT or RUN. State is unchanged.
//  bp_match = bp_valid & (pc == bp_addr) & ~bp_skip & (state==RUN).
//  pipe_en = ((state==RUN) & ~bp_match) | (state==STEP).
//   Combinational on the registered pc, so there is no loop.
//  RUN: when bp_match=1, that cycle has pipe_en=0.
//   At the edge: state <= HALT, bp_hit <= 1, bp_skip <= 1.
//  bp_skip: cleared at the end of the first cycle with pipe_en=1.
//   This lets RUN/STEP resume past the breakpoint instruction.
//   A new SET_BP also clears bp_skip.
//  STEP: pipe_en=1 every cycle; step_left decrements each cycle.
//   When step_left==1, next state is HALT.
//   Result: exactly N enabled cycles, N=0 behaves as 1.
//   STEP ignores the breakpoint.
//  cycle_cnt increments by 1 on every edge with pipe_en=1.
//   Wraps modulo 2^CYC_W. It is never cleared except by reset.
//  HALT command and bp_match in the same cycle: next state HALT.
//   bp_hit is still set and pipe_en=0 that cycle.
//  Counter underflow: step_left never decrements below 1
//   (STEP exits on 1).
//  resetn low at any time (mid-STEP included): immediate return to the
//   reset values; pipe_en drops without waiting for the clock.
// TESTING
//  Reset, RUN accepted at edge 0 -> pipe_en=1 from cycle 1;
//   after 10 cycles cycle_cnt=10, state=01.
//  From HALT, STEP N=3 -> pipe_en=1 for exactly 3 cycles, cmd_ready=0
//   throughout, then halted=1, cycle_cnt+=3.
//  STEP N=0 -> exactly 1 enabled cycle, then HALT; STEP N=1 identical.
//  SET_BP 0x0000_0040, RUN, pc steps by 4 from 0 ->
//   pipe_en=0 in the cycle pc==0x40, bp_hit=1, state=HALT;
//   RUN again -> pipe_en=1 at pc 0x40, execution continues, bp_hit=0.
//  HALT and bp_match in the same cycle -> state HALT, bp_hit=1.
//   SET_BP 0x41 (disable) then RUN -> passes 0x40 without stopping.
//  resetn pulsed low mid-STEP (step_left=5) -> pipe_en=0 at once,
//   cycle_cnt=0, state=HALT, cmd_ready=1.

Source files
------------

// File: rtl/pipe_run_ctrl.sv
// Purpose : run/halt/single-step controller producing the pipeline cycle-enable.
// Latency : an accepted command changes state at its edge; pipe_en follows one cycle later.
// Backpr. : cmd_ready is low for the whole of a STEP, so commands wait until it ends.
//
// Ports:
//   clock, resetn        clock and asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_op = HALT/RUN/STEP/SET_BP, cmd_arg operand
//   pc                   registered PC of the pipeline (compared against the breakpoint)
//   pipe_en              cycle-enable for PC, pipeline registers, RF and RAM writes
//   halted, state        run state (00 HALT, 01 RUN, 10 STEP)
//   bp_hit               sticky flag: the last stop came from the breakpoint
//   cycle_cnt            free-running count of enabled cycles
module pipe_run_ctrl #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_arg,
    input  logic [31:0]      pc,
    output logic             pipe_en,
    output logic             halted,
    output logic             bp_hit,
    output logic [1:0]       state,
    output logic [CYC_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    localparam logic [1:0] OP_HALT   = 2'b00;
    localparam logic [1:0] OP_RUN    = 2'b01;
    localparam logic [1:0] OP_STEP   = 2'b10;
    localparam logic [1:0] OP_SET_BP = 2'b11;

    state_t           st_q, st_d;
    logic [CNT_W-1:0] step_left_q, step_left_d;
    logic [31:0]      bp_addr_q, bp_addr_d;
    logic             bp_valid_q, bp_valid_d;
    logic             bp_skip_q, bp_skip_d;
    logic             bp_hit_q, bp_hit_d;
    logic [CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;

    logic             cmd_acc;
    logic             bp_match;
    logic [CNT_W-1:0] step_n;

    assign cmd_ready = (st_q != ST_STEP);
    assign cmd_acc   = cmd_valid & cmd_ready;
    assign step_n    = cmd_arg[CNT_W-1:0];

    // bp_skip suppresses the match on the instruction we just stopped at,
    // so RUN can resume past it.
    assign bp_match  = bp_valid_q & (pc == bp_addr_q) & ~bp_skip_q & (st_q == ST_RUN);
    assign pipe_en   = ((st_q == ST_RUN) & ~bp_match) | (st_q == ST_STEP);

    assign halted    = (st_q == ST_HALT);
    assign state     = st_q;
    assign bp_hit    = bp_hit_q;
    assign cycle_cnt = cycle_cnt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            st_q        <= ST_HALT;
            step_left_q <= '0;
            bp_addr_q   <= '0;
            bp_valid_q  <= 1'b0;
            bp_skip_q   <= 1'b0;
            bp_hit_q    <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            st_q        <= st_d;
            step_left_q <= step_left_d;
            bp_addr_q   <= bp_addr_d;
            bp_valid_q  <= bp_valid_d;
            bp_skip_q   <= bp_skip_d;
            bp_hit_q    <= bp_hit_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    always_comb begin
        st_d        = st_q;
        step_left_d = step_left_q;
        bp_addr_d   = bp_addr_q;
        bp_valid_d  = bp_valid_q;
        bp_skip_d   = bp_skip_q;
        bp_hit_d    = bp_hit_q;
        cycle_cnt_d = cycle_cnt_q;

        if (pipe_en) begin
            cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
            bp_skip_d   = 1'b0;
        end

        if (st_q == ST_STEP) begin
            // Exit on 1 rather than decrementing to 0; the count never underflows.
            if (step_left_q > CNT_W'(1)) begin
                step_left_d = step_left_q - CNT_W'(1);
            end else begin
                st_d = ST_HALT;
            end
        end else if (cmd_acc) begin
            case (cmd_op)
                OP_HALT: st_d = ST_HALT;
                OP_RUN: begin
                    st_d     = ST_RUN;
                    bp_hit_d = 1'b0;
                end
                OP_STEP: begin
                    st_d        = ST_STEP;
                    step_left_d = (step_n == '0) ? CNT_W'(1) : step_n;
                    bp_hit_d    = 1'b0;
                end
                OP_SET_BP: begin
                    // Word-align the address; bit 0 of the argument disables.
                    bp_addr_d  = cmd_arg & 32'hFFFF_FFFC;
                    bp_valid_d = ~cmd_arg[0];
                    bp_skip_d  = 1'b0;
                end
                default: st_d = st_q;
            endcase
        end

        // A breakpoint stop wins over any command accepted in the same cycle
        // (a SET_BP still loads its address).
        if (bp_match) begin
            st_d      = ST_HALT;
            bp_hit_d  = 1'b1;
            bp_skip_d = 1'b1;
        end
    end

endmodule
